serial_add_ctrl: RTL
====================

# serial_add_ctrl

Sequencer that computes WIDTH-bit additions on a single-bit full-adder stage, one bit per clock, LSB first. It accepts operand pairs over a valid/ready handshake, drives the bit-serial stage while holding the inter-bit carry in a register, and returns the WIDTH-bit sum plus carry-out over a second valid/ready handshake. It sits between a word-wide requester and the team's 1-bit adder datapath and trades area for WIDTH cycles of latency.

## Interface
- WIDTH, 8: operand/sum width in bits; legal range 1..32.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  controller can accept operands; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op_sub  in  1  1 = compute a - b (SERIAL_ADD_SUB_EN only; ignored otherwise).
- out_valid  out  1  result present; held until taken.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result word.
- c_out  out  1  final carry; in subtract mode 1 = no borrow.
- busy  out  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid && in_ready: latch a and b into shift registers (b inverted if subtract), set carry register to 0 (add) or 1 (subtract), clear bit counter, go to RUN.
- RUN: feed a_sh[0], b_sh[0], carry into full-adder stage. Each cycle: shift stage sum bit into sum register MSB, right-shift sum register, shift a_sh/b_sh right, carry <= stage carry, counter++. On the edge processing bit WIDTH-1: go to DONE, c_out <= stage carry.
- DONE: out_valid=1, sum/c_out stable. On out_ready: go to IDLE. In DONE, in_valid is not accepted (in_ready=0).
- Arithmetic: sum = (a + b + cin) mod 2^WIDTH, c_out = bit WIDTH of the full sum; cin = 0 for add, 1 for subtract with b inverted.
- Counter width: $clog2(WIDTH+1); it never wraps within one operation.
- Inputs a, b, op_sub are sampled only on the accept edge; later changes are ignored.
- out_ready while out_valid=0 has no effect.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, busy=0, sum=0, c_out=0; carry, counter and shift registers cleared.
- Reset asserted mid-operation: aborts immediately; the operation is lost and no result is produced.
- Accept on edge T0. out_valid rises after edge T0+WIDTH.
- If out_ready is high in the first DONE cycle, the result is taken on edge T0+WIDTH+1 and in_ready is high in the following cycle.
- Sustained throughput is one operation per WIDTH+2 cycles.
- WIDTH=1: RUN lasts exactly one cycle.
- out_valid and sum are registered. in_ready and busy are decoded from registered state. There is no combinational path from inputs to outputs.

## Configuration
- SERIAL_ADD_SUB_EN defined: op_sub is honoured. Subtract inverts b at load and presets carry to 1, so sum = a - b mod 2^WIDTH and c_out=1 when a >= b (unsigned).
- SERIAL_ADD_SUB_EN undefined: op_sub is unconnected internally, all operations are additions, and the inversion mux is removed.

## Structure
- Package serial_add_pkg holds the FSM state typedef (IDLE/RUN/DONE encoding) and the default WIDTH constant.
- Sub-module serial_fa_stage holds the single-bit full adder (a, b, c_in -> sum, c_out, combinational). The controller instantiates it once.
- The controller owns all registers: shift registers, carry, counter, state.

## Test plan
- WIDTH=8, a=0x35, b=0x4A, out_ready=1 -> sum=0x7F, c_out=0; out_valid rises 8 cycles after accept.
- a=0xFF, b=0x01 -> sum=0x00, c_out=1. Then a=0x80, b=0x80 -> sum=0x00, c_out=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> sum and c_out held stable, in_ready=0 throughout, and the result is consumed on the first out_ready=1.
- Reset pulsed low 3 cycles into RUN -> all outputs at reset values, in_ready=1. The next operation 0x12+0x34 gives 0x46, c_out=0.
- SERIAL_ADD_SUB_EN defined: 0x10 - 0x01 -> sum=0x0F, c_out=1; 0x01 - 0x02 -> sum=0xFF, c_out=0. Undefined: 0x10 with op_sub=1, b=0x01 -> sum=0x11.
- Back-to-back requests with in_valid held high -> the second is accepted only after the first result is taken; no operand is lost or duplicated.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/serial_fa_stage.sv
// Single-bit full adder: the combinational datapath stage driven one bit per clock.
module serial_fa_stage (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer, LSB first, valid/ready on both sides.
// Define SERIAL_ADD_SUB_EN to honour op_sub (a - b via b inversion and carry preset).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, sum_r, sum_nxt, b_ld;
  logic [CW-1:0]    cnt;
  logic             carry, c_out_r, out_valid_r;
  logic             st_sum, st_cout, sub, last;

`ifdef SERIAL_ADD_SUB_EN
  assign sub  = op_sub;
  assign b_ld = sub ? ~b : b;
`else
  logic unused_op_sub;
  assign unused_op_sub = op_sub;
  assign sub  = 1'b0;
  assign b_ld = b;
`endif

  serial_fa_stage u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .c_in (carry),
    .sum  (st_sum),
    .c_out(st_cout)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  // Result assembles MSB-first into the top so it is aligned after WIDTH shifts.
  always_comb begin
    sum_nxt = sum_r >> 1;
    sum_nxt[WIDTH-1] = st_sum;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      sum_r       <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      c_out_r     <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          a_sh  <= a;
          b_sh  <= b_ld;
          carry <= sub;
          cnt   <= '0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          sum_r <= sum_nxt;
          carry <= st_cout;
          cnt   <= cnt + CW'(1);
          if (last) begin
            state       <= ST_DONE;
            out_valid_r <= 1'b1;
            c_out_r     <= st_cout;
          end
        end
        ST_DONE: if (out_ready) begin
          state       <= ST_IDLE;
          out_valid_r <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign c_out     = c_out_r;

endmodule
